batchnorm_inverse_unscale: RTL and testbench

Inverse of the batch-norm scale/shift stage. It recovers the pre-normalisation activation x = ((y - BETA) << FRAC) / GAMMA from a normalised sample y. It is used on the debug/readback path and by the calibration loop to map normalised feature values back into the raw accumulator domain. The block has a valid/ready stream on each side and uses a multi-cycle sequential restoring divider, so it accepts one sample at a time.

---
 rtl/batchnorm_inverse_unscale_if.sv | 23 ++
 rtl/batchnorm_inverse_unscale.sv | 174 +++++++++++++++++
 tb/tb_batchnorm_inverse_unscale.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/batchnorm_inverse_unscale_if.sv
// Stream bundle for batchnorm_inverse_unscale: sample in (valid/ready) and
// recovered sample out (valid/ready with saturation flag).
interface batchnorm_inverse_unscale_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/batchnorm_inverse_unscale.sv
// Inverse batch-norm unscale: x = ((y - BETA) << FRAC) / GAMMA, computed with
// a bit-serial restoring divider (one quotient bit per cycle), saturated to DATA_W.
module batchnorm_inverse_unscale #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC   = 4,
  parameter int          GAMMA  = 1 << FRAC,
  parameter int          BETA   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  batchnorm_inverse_unscale_if.slave   bus
);

  localparam int unsigned DIFF_W = DATA_W + 1;
  localparam int unsigned NUM_W  = DATA_W + 1 + FRAC;
  localparam int unsigned REM_W  = NUM_W + 1;
  localparam int unsigned CNT_W  = $clog2(NUM_W);

  localparam logic [DIFF_W-1:0] BETA_X  = DIFF_W'(BETA);
  localparam logic [REM_W-1:0]  GAMMA_U = REM_W'(GAMMA);
  localparam logic [NUM_W-1:0]  POS_LIM = NUM_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic [NUM_W-1:0]  NEG_LIM = NUM_W'(2 ** (DATA_W - 1));
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W - 1){1'b0}}};

  // Elaboration-time guard on the divisor range.
  if (GAMMA <= 0) begin : g_gamma_low
    $error("batchnorm_inverse_unscale: GAMMA must be positive");
  end
  if (GAMMA >= (2 ** (DATA_W + FRAC))) begin : g_gamma_high
    $error("batchnorm_inverse_unscale: GAMMA exceeds 2^(DATA_W+FRAC)-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [NUM_W-1:0]  rem_q, rem_d;
  logic [NUM_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic              out_valid_q, out_valid_d;

  // Operand preparation: sign-extended difference, scaled, split into sign/magnitude.
  logic [DIFF_W-1:0] diff_c;
  logic [NUM_W-1:0]  num_c;
  logic              sign_c;
  logic [NUM_W-1:0]  mag_c;

  always_comb begin
    diff_c = {bus.in_data[DATA_W-1], bus.in_data} - BETA_X;
    num_c  = {diff_c, {FRAC{1'b0}}};
    sign_c = num_c[NUM_W-1];
    mag_c  = sign_c ? ((~num_c) + NUM_W'(1)) : num_c;
  end

  // One restoring step plus saturation of the quotient it would complete.
  logic [REM_W-1:0]  rem_sh_c;
  logic [REM_W-1:0]  rem_sub_c;
  logic              q_bit_c;
  logic [NUM_W-1:0]  rem_nxt_c;
  logic [NUM_W-1:0]  quo_nxt_c;
  logic [DATA_W-1:0] res_c;
  logic              sat_c;

  always_comb begin
    rem_sh_c  = {rem_q, num_q[NUM_W-1]};
    rem_sub_c = rem_sh_c - GAMMA_U;
    q_bit_c   = (rem_sh_c >= GAMMA_U);
    rem_nxt_c = q_bit_c ? NUM_W'(rem_sub_c) : NUM_W'(rem_sh_c);
    quo_nxt_c = {quo_q[NUM_W-2:0], q_bit_c};
    res_c     = '0;
    sat_c     = 1'b0;
    if (sign_q) begin
      if (quo_nxt_c > NEG_LIM) begin
        res_c = SAT_NEG;
        sat_c = 1'b1;
      end else begin
        res_c = DATA_W'((~quo_nxt_c) + NUM_W'(1));
      end
    end else begin
      if (quo_nxt_c > POS_LIM) begin
        res_c = SAT_POS;
        sat_c = 1'b1;
      end else begin
        res_c = DATA_W'(quo_nxt_c);
      end
    end
  end

  // Next-state and register-next logic.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          num_d   = mag_c;
          sign_d  = sign_c;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(NUM_W - 1);
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        num_d = {num_q[NUM_W-2:0], 1'b0};
        rem_d = rem_nxt_c;
        quo_d = quo_nxt_c;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          out_data_d  = res_c;
          out_sat_d   = sat_c;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready decodes the state register only, so no in_* to out_* path exists.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_batchnorm_inverse_unscale.sv
// Directed bench: four DUT configurations (GAMMA/BETA), vector table plus
// backpressure and mid-operation reset sequences.
module tb_batchnorm_inverse_unscale;

  localparam int unsigned NCFG    = 4;
  localparam int          EXP_LAT = 13;

  logic clk;
  logic rst;

  logic [NCFG-1:0][7:0] in_data_a;
  logic [NCFG-1:0]      in_valid_a;
  logic [NCFG-1:0]      out_ready_a;
  wire  [NCFG-1:0]      in_ready_w;
  wire  [NCFG-1:0][7:0] out_data_w;
  wire  [NCFG-1:0]      out_sat_w;
  wire  [NCFG-1:0]      out_valid_w;

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cfg0: GAMMA=16 BETA=0, cfg1: 32/3, cfg2: 24/0, cfg3: 8/0
  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int GAM = (g == 0) ? 16 : (g == 1) ? 32 : (g == 2) ? 24 : 8;
    localparam int BET = (g == 1) ? 3 : 0;

    batchnorm_inverse_unscale_if #(.DATA_W(8)) bus ();

    assign bus.in_data   = in_data_a[g];
    assign bus.in_valid  = in_valid_a[g];
    assign bus.out_ready = out_ready_a[g];
    assign in_ready_w[g]  = bus.in_ready;
    assign out_data_w[g]  = bus.out_data;
    assign out_sat_w[g]   = bus.out_sat;
    assign out_valid_w[g] = bus.out_valid;

    batchnorm_inverse_unscale #(
      .DATA_W(8),
      .FRAC  (4),
      .GAMMA (GAM),
      .BETA  (BET)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
    );
  end

  typedef struct {
    int         cfg;
    logic [7:0] din;
    logic [7:0] dout;
    logic       sat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Accepts one sample on config c, waits (bounded) for the result; leaves
  // out_valid pending if out_ready is low. Returns edges from accept to out_valid.
  task automatic send(input int c, input logic [7:0] din, output int lat);
    in_data_a[c]  = din;
    in_valid_a[c] = 1'b1;
    chk($sformatf("cfg%0d in_ready before accept", c), int'(in_ready_w[c]), 1);
    @(posedge clk); #1;
    in_valid_a[c] = 1'b0;
    lat = 0;
    while (!out_valid_w[c] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    vecs[0]  = '{0, 8'd37,   8'd37,   1'b0};
    vecs[1]  = '{0, 8'h80,   8'h80,   1'b0};
    vecs[2]  = '{0, 8'd127,  8'd127,  1'b0};
    vecs[3]  = '{1, 8'd23,   8'd10,   1'b0};
    vecs[4]  = '{1, 8'hEF,   8'hF6,   1'b0};  // -17 -> -10
    vecs[5]  = '{1, 8'h80,   8'hBF,   1'b0};  // -128 -> -65
    vecs[6]  = '{2, 8'd10,   8'd6,    1'b0};
    vecs[7]  = '{2, 8'hF6,   8'hFA,   1'b0};  // -10 -> -6
    vecs[8]  = '{2, 8'd127,  8'd84,   1'b0};
    vecs[9]  = '{2, 8'h80,   8'hAB,   1'b0};  // -128 -> -85
    vecs[10] = '{3, 8'd100,  8'd127,  1'b1};
    vecs[11] = '{3, 8'h80,   8'h80,   1'b1};
    vecs[12] = '{3, 8'd50,   8'd100,  1'b0};
    vecs[13] = '{3, 8'hC0,   8'h80,   1'b0};  // -64 -> exactly -128
    vecs[14] = '{3, 8'd64,   8'd127,  1'b1};
    vecs[15] = '{3, 8'd0,    8'd0,    1'b0};

    rst         = 1'b1;
    in_data_a   = '0;
    in_valid_a  = '0;
    out_ready_a = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("cfg%0d reset in_ready", c),  int'(in_ready_w[c]),  1);
      chk($sformatf("cfg%0d reset out_valid", c), int'(out_valid_w[c]), 0);
      chk($sformatf("cfg%0d reset out_data", c),  int'(out_data_w[c]),  0);
      chk($sformatf("cfg%0d reset out_sat", c),   int'(out_sat_w[c]),   0);
    end

    for (int i = 0; i < 16; i++) begin
      int c;
      c = vecs[i].cfg;
      send(c, vecs[i].din, lat);
      chk($sformatf("vec%0d latency", i), lat, EXP_LAT);
      chk($sformatf("vec%0d out_data", i), int'($signed(out_data_w[c])),
          int'($signed(vecs[i].dout)));
      chk($sformatf("vec%0d out_sat", i), int'(out_sat_w[c]), int'(vecs[i].sat));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid after accept", i), int'(out_valid_w[c]), 0);
      chk($sformatf("vec%0d in_ready after accept", i), int'(in_ready_w[c]), 1);
    end

    // Backpressure: result and flags held, no input accepted while pending.
    out_ready_a[3] = 1'b0;
    send(3, 8'd100, lat);
    chk("bp latency", lat, EXP_LAT);
    for (int k = 0; k < 5; k++) begin
      in_valid_a[3] = 1'b1;
      in_data_a[3]  = 8'd5;
      @(posedge clk); #1;
      chk($sformatf("bp hold%0d out_valid", k), int'(out_valid_w[3]), 1);
      chk($sformatf("bp hold%0d out_data", k),  int'(out_data_w[3]), 127);
      chk($sformatf("bp hold%0d out_sat", k),   int'(out_sat_w[3]), 1);
      chk($sformatf("bp hold%0d in_ready", k),  int'(in_ready_w[3]), 0);
    end
    in_valid_a[3]  = 1'b0;
    out_ready_a[3] = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", int'(out_valid_w[3]), 0);
    chk("bp release in_ready",  int'(in_ready_w[3]), 1);

    // Mid-division reset on cfg0, whose out_data still holds an earlier result.
    in_data_a[0]  = 8'd37;
    in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst mid out_valid", int'(out_valid_w[0]), 0);
    chk("rst mid in_ready",  int'(in_ready_w[0]), 1);
    chk("rst mid out_data",  int'(out_data_w[0]), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("rst mid no stray out_valid", int'(out_valid_w[0]), 0);
    send(0, 8'd37, lat);
    chk("post-rst latency",  lat, EXP_LAT);
    chk("post-rst out_data", int'(out_data_w[0]), 37);
    chk("post-rst out_sat",  int'(out_sat_w[0]), 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
